// File: rtl/trace_pkg.sv
// Shared definitions for the commit trace buffer: capture modes, FSM state
// encoding and the entry layout (wdata, inst, pc, rd, rf_we, exc, [ts]).
package trace_pkg;

  localparam logic [1:0] MODE_FIFO = 2'b00;
  localparam logic [1:0] MODE_WRAP = 2'b01;
  localparam logic [1:0] MODE_TRIG = 2'b10;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_POST   = 2'd2;
  localparam logic [1:0] ST_FROZEN = 2'd3;

  localparam int RD_W   = 5;
  localparam int META_W = RD_W + 2;

  function automatic int off_inst(int xlen);
    return xlen;
  endfunction

  function automatic int off_pc(int xlen);
    return 2 * xlen;
  endfunction

  function automatic int off_rd(int xlen);
    return 3 * xlen;
  endfunction

  function automatic int off_rf_we(int xlen);
    return 3 * xlen + RD_W;
  endfunction

  function automatic int off_exc(int xlen);
    return 3 * xlen + RD_W + 1;
  endfunction

  function automatic int off_ts(int xlen);
    return 3 * xlen + META_W;
  endfunction

  function automatic int entry_w(int xlen, int ts_w, bit ts_en);
    return 3 * xlen + META_W + (ts_en ? ts_w : 0);
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace entry storage: one synchronous write port, one asynchronous read port.
// No reset; entry validity is tracked entirely by the top-level pointers.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int EW    = 103,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [EW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [EW-1:0] rdata_o
);

  logic [EW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/commit_trace_buffer.sv
// Retire-trace recorder beside WB: circular buffer with FIFO/WRAP/TRIG capture.
// Define TRACE_TIMESTAMP_EN to append a free-running cycle stamp to each entry.
module commit_trace_buffer
  import trace_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 16,
  parameter int TS_W  = 16,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1,
`ifdef TRACE_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1,
`else
  localparam bit TS_EN = 1'b0,
`endif
  localparam int EW   = entry_w(XLEN, TS_W, TS_EN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_valid,
  input  logic [XLEN-1:0] wb_pc,
  input  logic [XLEN-1:0] wb_inst,
  input  logic            wb_rf_we,
  input  logic [4:0]      wb_wb_reg,
  input  logic [XLEN-1:0] wb_data,
  input  logic            wb_exc,
  input  logic [1:0]      cfg_mode,
  input  logic            cfg_arm,
  input  logic            cfg_stop,
  input  logic [XLEN-1:0] cfg_trig_pc,
  input  logic [CW-1:0]   cfg_post,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [EW-1:0]   rd_data,
  output logic [CW-1:0]   count,
  output logic            overflow,
  output logic [15:0]     drop_cnt,
  output logic [1:0]      state
);

  logic [1:0]    state_q, state_d;
  logic [1:0]    mode_q, mode_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] post_q, post_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_q, drop_d;

  logic          recording, full, pop, cap, drop, evict, wr_en, trig_hit;
  logic [EW-1:0] entry;

`ifdef TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  // Free-running stamp; arm deliberately leaves it alone so stamps stay monotonic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts_q <= '0;
    else        ts_q <= ts_q + TS_W'(1);
  end

  assign entry = {ts_q, wb_exc, wb_rf_we, wb_wb_reg, wb_pc, wb_inst, wb_data};
`else
  assign entry = {wb_exc, wb_rf_we, wb_wb_reg, wb_pc, wb_inst, wb_data};
`endif

  assign recording = (state_q == ST_RUN) || (state_q == ST_POST);
  assign full      = (count_q == CW'(DEPTH));
  assign pop       = rd_valid && rd_ready;
  assign cap       = wb_valid && recording && !cfg_arm;
  // A same-cycle pop frees a slot, so a full buffer only loses data without one.
  assign drop      = cap && full && !pop && (mode_q == MODE_FIFO);
  assign evict     = cap && full && !pop && (mode_q != MODE_FIFO);
  assign wr_en     = cap && !drop;
  assign trig_hit  = cap && (state_q == ST_RUN) && (mode_q == MODE_TRIG) &&
                     (wb_pc == cfg_trig_pc);

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    post_d     = post_q;
    overflow_d = overflow_q;
    drop_d     = drop_q;

    if (cfg_arm) begin
      state_d    = ST_RUN;
      // Reserved encoding is folded into WRAP at latch time.
      mode_d     = ((cfg_mode == MODE_FIFO) || (cfg_mode == MODE_TRIG)) ? cfg_mode : MODE_WRAP;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      post_d     = '0;
      overflow_d = 1'b0;
      drop_d     = '0;
    end else begin
      if (wr_en)        wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop || evict) rd_ptr_d = rd_ptr_q + AW'(1);

      if (wr_en && !pop && !evict) count_d = count_q + CW'(1);
      else if (pop && !wr_en)      count_d = count_q - CW'(1);

      if (drop || evict) begin
        overflow_d = 1'b1;
        if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
      end

      if (cfg_stop && recording) begin
        state_d = ST_IDLE;
      end else if (trig_hit) begin
        post_d  = cfg_post;
        state_d = (cfg_post == '0) ? ST_FROZEN : ST_POST;
      end else if (cap && (state_q == ST_POST)) begin
        post_d = post_q - CW'(1);
        if (post_q == CW'(1)) state_d = ST_FROZEN;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_FIFO;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      post_q     <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      post_q     <= post_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .EW    (EW)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (entry),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  assign rd_valid = (count_q != '0);
  assign count    = count_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_q;
  assign state    = state_q;

endmodule
